// File: rtl/ipm_fifo_pkg.sv
// Shared constants and helpers for the ipm synchronous FIFO family.
// Read-mode selectors and the width of the occupancy counter.
package ipm_fifo_pkg;

   localparam bit FIFO_STD  = 1'b0;
   localparam bit FIFO_FWFT = 1'b1;

   // The level counter must be able to represent a completely full FIFO (DEPTH = 2^addr_w).
   function automatic int level_w(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/ipm_fifo_sdpram_v2_0.sv
// Simple dual-port RAM: one write port and one read port with a registered output.
// The output register holds its value between reads and resets to zero.
module ipm_fifo_sdpram_v2_0 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ipm_sync_fifo_v2_0.sv
// Single-clock FIFO with standard or first-word-fall-through read, registered flags and
// sticky overflow/underflow. FWFT mode adds a 2-entry prefetch buffer in front of the RAM.
module ipm_sync_fifo_v2_0
   import ipm_fifo_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter bit FWFT_EN = FIFO_STD,
   parameter int AF_NUM  = (1 << ADDR_W) - 4,
   parameter int AE_NUM  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_full,
   output logic                          almost_full,
   input  logic                          rd_en,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_vld,
   output logic                          rd_empty,
   output logic                          almost_empty,
   output logic [level_w(ADDR_W)-1:0]    level,
   input  logic                          err_clr,
   output logic                          wr_ovf,
   output logic                          rd_udf
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam int              LW      = level_w(ADDR_W);
   localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0]   AF_L    = LW'(AF_NUM);
   localparam logic [LW-1:0]   AE_L    = LW'(AE_NUM);

   logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [LW-1:0]     level_d, level_q;
   logic [LW-1:0]     ram_cnt_d, ram_cnt_q;
   logic              full_d, full_q;
   logic              af_d, af_q;
   logic              empty_d, empty_q;
   logic              ae_d, ae_q;
   logic              ovf_d, ovf_q;
   logic              udf_d, udf_q;
   logic              rd_vld_d, rd_vld_q;

   logic [1:0]        ob_cnt_d, ob_cnt_q;
   logic [DATA_W-1:0] ob0_d, ob0_q;
   logic [DATA_W-1:0] ob1_d, ob1_q;
   logic              fetch_d, fetch_q;

   logic              wr_acc, can_pop, pop, ram_rd, ob_pop;
   logic [1:0]        occ;
   logic [DATA_W-1:0] ram_dout;

   ipm_fifo_sdpram_v2_0 #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_dout)
   );

   // Accept/pop decisions. The RAM never reads a slot written on the same edge: a read
   // needs ram_cnt>0, and a write needs level<DEPTH, so the two pointers differ.
   always_comb begin
      wr_acc  = wr_en & ~full_q;
      can_pop = FWFT_EN ? rd_vld_q : ~empty_q;
      pop     = rd_en & can_pop;
      ob_pop  = FWFT_EN & pop;
      // Words buffered plus the one in flight out of the RAM.
      occ     = ob_cnt_q + {1'b0, fetch_q};
      if (FWFT_EN) ram_rd = (ram_cnt_q != '0) && ((occ < 2'd2) || pop);
      else         ram_rd = pop;
      fetch_d = FWFT_EN & ram_rd;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d  = rd_ptr_q + ADDR_W'(ram_rd);
      level_d   = level_q;
      ram_cnt_d = ram_cnt_q;
      unique case ({wr_acc, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      unique case ({wr_acc, ram_rd})
         2'b10:   ram_cnt_d = ram_cnt_q + LW'(1);
         2'b01:   ram_cnt_d = ram_cnt_q - LW'(1);
         default: ram_cnt_d = ram_cnt_q;
      endcase
   end

   // Output buffer: ob0 is the head, ob1 the next word. A RAM word lands the edge after fetch.
   always_comb begin
      ob_cnt_d = ob_cnt_q;
      ob0_d    = ob0_q;
      ob1_d    = ob1_q;
      unique case ({fetch_q, ob_pop})
         2'b01: begin
            if (ob_cnt_q == 2'd2) ob0_d = ob1_q;
            ob_cnt_d = ob_cnt_q - 2'd1;
         end
         2'b10: begin
            if (ob_cnt_q == 2'd0) ob0_d = ram_dout;
            else                  ob1_d = ram_dout;
            ob_cnt_d = ob_cnt_q + 2'd1;
         end
         2'b11: begin
            if (ob_cnt_q == 2'd2) begin
               ob0_d = ob1_q;
               ob1_d = ram_dout;
            end else begin
               ob0_d = ram_dout;
            end
         end
         default: ob_cnt_d = ob_cnt_q;
      endcase
   end

   always_comb begin
      full_d = (level_d == DEPTH_L);
      af_d   = (level_d >= AF_L);
      ae_d   = (level_d <= AE_L);
      if (FWFT_EN) begin
         rd_vld_d = (ob_cnt_d != 2'd0);
         empty_d  = (ob_cnt_d == 2'd0);
      end else begin
         rd_vld_d = pop;
         empty_d  = (level_d == '0);
      end
      // A fresh error on the same edge takes priority over the clear.
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (wr_en & full_q)    ovf_d = 1'b1;
      if (rd_en & ~can_pop)  udf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ram_cnt_q <= '0;
         full_q    <= 1'b0;
         af_q      <= 1'b0;
         empty_q   <= 1'b1;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         ob_cnt_q  <= 2'd0;
         ob0_q     <= '0;
         ob1_q     <= '0;
         fetch_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ram_cnt_q <= ram_cnt_d;
         full_q    <= full_d;
         af_q      <= af_d;
         empty_q   <= empty_d;
         ae_q      <= ae_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rd_vld_q  <= rd_vld_d;
         ob_cnt_q  <= ob_cnt_d;
         ob0_q     <= ob0_d;
         ob1_q     <= ob1_d;
         fetch_q   <= fetch_d;
      end
   end

   assign wr_full      = full_q;
   assign almost_full  = af_q;
   assign rd_empty     = empty_q;
   assign almost_empty = ae_q;
   assign level        = level_q;
   assign wr_ovf       = ovf_q;
   assign rd_udf       = udf_q;
   assign rd_vld       = rd_vld_q;
   assign rd_data      = FWFT_EN ? ob0_q : ram_dout;

endmodule
